// File: rtl/word_io_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : word_io_pkg
//  Description : Shared definitions for the word echo buffer: transform mode
//                codes, send-FSM state encoding and a byte-reverse helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package word_io_pkg;

  // Transform selection codes for the MODE parameter
  localparam int MODE_ECHO = 0;
  localparam int MODE_BREV = 1;
  localparam int MODE_INC  = 2;
  localparam int MODE_INV  = 3;

  // Widest word byte_reverse can handle; callers cast to/from their width
  localparam int MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } send_state_t;

  // Reverses the byte order of the low nbytes bytes of word; upper bytes of
  // the result are zero.
  function automatic logic [MAX_WIDTH-1:0] byte_reverse(
    input logic [MAX_WIDTH-1:0] word,
    input int                   nbytes
  );
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH / 8; i++) begin
      if (i < nbytes) r[8*i +: 8] = word[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_echo_buf_if.sv
`default_nettype none
// ============================================================================
//  Interface   : word_echo_buf_if
//  Description : Receiver/sender handshake bundle of the word echo buffer.
//  Signals     : in_data   receiver word, valid while in_avail is high
//                in_avail  receiver level flag, rising edge = new word
//                out_ready sender idle / able to accept a word
//                out_data  word to the sender
//                out_send  one-cycle send strobe
//  Modports    : master = environment side, slave = echo buffer side
//  Revision    : 1.0  initial release
// ============================================================================
interface word_echo_buf_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_avail;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_send;

  modport master (
    output in_data, in_avail, out_ready,
    input  out_data, out_send
  );

  modport slave (
    input  in_data, in_avail, out_ready,
    output out_data, out_send
  );
endinterface
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : word_fifo
//  Description : Synchronous FIFO with show-ahead read data. A push into a
//                full FIFO is accepted only when a pop happens in the same
//                cycle.
//  Ports       : clk, rst_n (async active-low, clears pointers)
//                i_push/i_wdata  write request and data
//                i_pop           read request (ignored when empty)
//                o_rdata         word at the head of the FIFO
//                o_full/o_empty  status flags
//                o_level         occupancy 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_wdata,
  input  wire logic                     i_pop,
  output logic      [WIDTH-1:0]         o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_level
);
  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   c_full_lvl = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra bit so full and empty are distinguishable
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == c_full_lvl);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_wr_en = i_push & (~o_full | i_pop);
  assign w_rd_en = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // When full, a simultaneous push overwrites the head slot; the head word
  // has already been read combinationally in that same cycle.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end
endmodule
`default_nettype wire

// File: rtl/word_echo_buf.sv
`default_nettype none
// ============================================================================
//  Module      : word_echo_buf
//  Description : Buffered word echo stage. Captures one word per rising edge
//                of in_avail, transforms it (MODE), queues it in a DEPTH-entry
//                FIFO and hands it to the sender with a one-cycle strobe.
//                Words arriving into a full FIFO are dropped and counted.
//  Ports       : clk, rst_n (async assert active-low)
//                bus        word_echo_buf_if.slave handshake bundle
//                level      FIFO occupancy
//                ovf_cnt    saturating count of dropped words
//                ovf_pulse  one-cycle pulse per dropped word
//  Revision    : 1.0  initial release
// ============================================================================
module word_echo_buf
  import word_io_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  parameter int OVF_W = 8
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  word_echo_buf_if.slave              bus,
  output logic [$clog2(DEPTH):0]      level,
  output logic [OVF_W-1:0]            ovf_cnt,
  output logic                        ovf_pulse
);
  logic             r_avail_q;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_xform;
  logic [WIDTH-1:0] w_rdata;
  send_state_t      r_state;

  // Edge detector; cleared by reset so a level already high at release
  // counts as a fresh word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_avail_q <= 1'b0;
    else        r_avail_q <= bus.in_avail;
  end

  assign w_push = bus.in_avail & ~r_avail_q;

  // Transform is applied on the way in so the FIFO stores final words
  always_comb begin
    w_xform = bus.in_data;
    case (MODE)
      MODE_BREV: w_xform = WIDTH'(byte_reverse(MAX_WIDTH'(bus.in_data), WIDTH / 8));
      MODE_INC:  w_xform = bus.in_data + WIDTH'(1);
      MODE_INV:  w_xform = ~bus.in_data;
      MODE_ECHO: w_xform = bus.in_data;
      default:   w_xform = bus.in_data;
    endcase
  end

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_xform),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Pops only from IDLE, so a word pushed into an empty FIFO always takes
  // one cycle before it can be sent (no bypass path).
  assign w_pop  = (r_state == ST_IDLE) & ~w_empty & bus.out_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  // SEND waits for ready to fall before WAIT looks for it to rise again, so
  // a sender that lowers ready late still sees only one strobe per cycle of
  // its ready signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      bus.out_send <= 1'b0;
      bus.out_data <= '0;
    end else begin
      bus.out_send <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            bus.out_data <= w_rdata;
            bus.out_send <= 1'b1;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: if (!bus.out_ready) r_state <= ST_WAIT;
        ST_WAIT: if (bus.out_ready)  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt   <= '0;
      ovf_pulse <= 1'b0;
    end else begin
      ovf_pulse <= w_drop;
      if (w_drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_word_echo_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_echo_buf
//  Description : Self-checking bench for word_echo_buf. Four instances (one
//                per MODE) share the same stimulus; a behavioural queue model
//                predicts the words each one must deliver.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_word_echo_buf;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_echo_buf_if #(.WIDTH(32)) b0 ();
  word_echo_buf_if #(.WIDTH(32)) b1 ();
  word_echo_buf_if #(.WIDTH(32)) b2 ();
  word_echo_buf_if #(.WIDTH(32)) b3 ();

  assign b1.in_data = b0.in_data;  assign b1.in_avail = b0.in_avail;  assign b1.out_ready = b0.out_ready;
  assign b2.in_data = b0.in_data;  assign b2.in_avail = b0.in_avail;  assign b2.out_ready = b0.out_ready;
  assign b3.in_data = b0.in_data;  assign b3.in_avail = b0.in_avail;  assign b3.out_ready = b0.out_ready;

  logic [2:0] lvl0, lvl1, lvl2, lvl3;
  logic [7:0] oc0, oc1, oc2, oc3;
  logic       op0, op1, op2, op3;

  word_echo_buf #(.WIDTH(32), .DEPTH(4), .MODE(0), .OVF_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .level(lvl0), .ovf_cnt(oc0), .ovf_pulse(op0));
  word_echo_buf #(.WIDTH(32), .DEPTH(4), .MODE(1), .OVF_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .level(lvl1), .ovf_cnt(oc1), .ovf_pulse(op1));
  word_echo_buf #(.WIDTH(32), .DEPTH(4), .MODE(2), .OVF_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave), .level(lvl2), .ovf_cnt(oc2), .ovf_pulse(op2));
  word_echo_buf #(.WIDTH(32), .DEPTH(4), .MODE(3), .OVF_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave), .level(lvl3), .ovf_cnt(oc3), .ovf_pulse(op3));

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] got0[$], got1[$], got2[$], got3[$];
  int          pulses   = 0;
  bit          auto_rdy = 1'b0;
  bit          rdy_manual = 1'b0;
  int          hold_k   = 0;
  int          low_l    = 2;

  // Reference transform, written from the mode definitions
  function automatic logic [31:0] xf(input int m, input logic [31:0] w);
    case (m)
      1:       return {w[7:0], w[15:8], w[23:16], w[31:24]};
      2:       return w + 32'd1;
      3:       return ~w;
      default: return w;
    endcase
  endfunction

  // Monitor: records every strobe and every overflow pulse
  initial begin
    forever begin
      @(posedge clk); #1;
      if (b0.out_send) begin
        got0.push_back(b0.out_data); got1.push_back(b1.out_data);
        got2.push_back(b2.out_data); got3.push_back(b3.out_data);
      end
      if (op0) pulses++;
    end
  end

  // Sender model: manual level, or auto (drop ready hold_k cycles after a
  // strobe, keep it low about low_l cycles, then raise it again)
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt   = 0;
    b0.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!auto_rdy) begin
        phase = 0;
        b0.out_ready = rdy_manual;
      end else begin
        case (phase)
          0: begin
            b0.out_ready = 1'b1;
            if (b0.out_send) begin phase = 1; cnt = hold_k; end
          end
          1: begin
            if (cnt == 0) begin b0.out_ready = 1'b0; phase = 2; cnt = low_l; end
            else cnt--;
          end
          default: begin
            if (cnt <= 1) begin b0.out_ready = 1'b1; phase = 0; end
            else cnt--;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    b0.in_data  = d;
    b0.in_avail = 1'b1;
    @(negedge clk);
    b0.in_avail = 1'b0;
  endtask

  task automatic clear_obs();
    got0.delete(); got1.delete(); got2.delete(); got3.delete();
    pulses = 0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    b0.in_avail = 1'b0;
    auto_rdy    = 1'b0;
    rdy_manual  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    clear_obs();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 400 && got0.size() < n; i++) tick();
    repeat (20) tick();
  endtask

  task automatic test_reset();
    b0.in_data  = '0;
    b0.in_avail = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (b0.out_send !== 1'b0) $display("FAIL rst_send: got %b want 0", b0.out_send); else n_pass++;
    n_checks++; if (b0.out_data !== 32'h0) $display("FAIL rst_data: got %h want 0", b0.out_data); else n_pass++;
    n_checks++; if (lvl0 !== 3'd0) $display("FAIL rst_level: got %0d want 0", lvl0); else n_pass++;
    n_checks++; if (oc0 !== 8'd0) $display("FAIL rst_ovf_cnt: got %0d want 0", oc0); else n_pass++;
    n_checks++; if (op0 !== 1'b0) $display("FAIL rst_ovf_pulse: got %b want 0", op0); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_echo();
    do_reset();
    rdy_manual = 1'b1;
    tick();
    @(negedge clk);
    b0.in_data  = 32'h41424344;
    b0.in_avail = 1'b1;
    tick();  // push edge
    n_checks++; if (b0.out_send !== 1'b0) $display("FAIL echo_no_bypass: got %b want 0", b0.out_send); else n_pass++;
    n_checks++; if (lvl0 !== 3'd1) $display("FAIL echo_level1: got %0d want 1", lvl0); else n_pass++;
    tick();  // send edge
    n_checks++; if (b0.out_send !== 1'b1) $display("FAIL echo_send: got %b want 1", b0.out_send); else n_pass++;
    n_checks++; if (b0.out_data !== 32'h41424344) $display("FAIL echo_data: got %h want 41424344", b0.out_data); else n_pass++;
    n_checks++; if (b1.out_data !== 32'h44434241) $display("FAIL echo_brev: got %h want 44434241", b1.out_data); else n_pass++;
    n_checks++; if (b2.out_data !== 32'h41424345) $display("FAIL echo_inc: got %h want 41424345", b2.out_data); else n_pass++;
    n_checks++; if (b3.out_data !== 32'hBEBDBCBB) $display("FAIL echo_inv: got %h want bebdbcbb", b3.out_data); else n_pass++;
    n_checks++; if (lvl0 !== 3'd0) $display("FAIL echo_level0: got %0d want 0", lvl0); else n_pass++;
    tick();
    n_checks++; if (b0.out_send !== 1'b0) $display("FAIL echo_one_cycle: got %b want 0", b0.out_send); else n_pass++;
    b0.in_avail = 1'b0;
    rdy_manual  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_transform();
    do_reset();
    auto_rdy = 1'b1; hold_k = 0; low_l = 2;
    push_word(32'h11223344);
    push_word(32'hFFFFFFFF);
    tick();
    drain(2);
    n_checks++; if (got0.size() != 2) $display("FAIL xf_count: got %0d want 2", got0.size()); else n_pass++;
    n_checks++; if (got1[0] !== 32'h44332211) $display("FAIL xf_brev: got %h want 44332211", got1[0]); else n_pass++;
    n_checks++; if (got2[1] !== 32'h00000000) $display("FAIL xf_inc_wrap: got %h want 0", got2[1]); else n_pass++;
    n_checks++; if (got3[0] !== 32'hEEDDCCBB) $display("FAIL xf_inv: got %h want eeddccbb", got3[0]); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    tick();
    n_checks++; if (lvl0 !== 3'd4) $display("FAIL ovf_level: got %0d want 4", lvl0); else n_pass++;
    n_checks++; if (oc0 !== 8'd1) $display("FAIL ovf_cnt: got %0d want 1", oc0); else n_pass++;
    n_checks++; if (pulses != 1) $display("FAIL ovf_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (got0.size() != 0) $display("FAIL ovf_no_send: got %0d want 0", got0.size()); else n_pass++;
    auto_rdy = 1'b1; hold_k = 0; low_l = 2;
    drain(4);
    n_checks++; if (got0.size() != 4) $display("FAIL ovf_drain_count: got %0d want 4", got0.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got0[i] !== 32'(i + 1)) $display("FAIL ovf_order[%0d]: got %h want %h", i, got0[i], 32'(i + 1));
      else n_pass++;
    end
    n_checks++; if (lvl0 !== 3'd0) $display("FAIL ovf_level_end: got %0d want 0", lvl0); else n_pass++;
  endtask

  task automatic test_held_avail();
    logic [31:0] d;
    do_reset();
    auto_rdy = 1'b1; hold_k = 1; low_l = 2;
    d = $urandom;
    @(negedge clk);
    b0.in_data  = d;
    b0.in_avail = 1'b1;
    repeat (20) @(negedge clk);
    b0.in_avail = 1'b0;
    repeat (20) tick();
    n_checks++; if (got0.size() != 1) $display("FAIL held_sends: got %0d want 1", got0.size()); else n_pass++;
    n_checks++; if (got0[0] !== d) $display("FAIL held_data: got %h want %h", got0[0], d); else n_pass++;
    n_checks++; if (lvl0 !== 3'd0) $display("FAIL held_level: got %0d want 0", lvl0); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] w[5];
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) push_word(w[i]);
    tick();
    n_checks++; if (lvl0 !== 3'd4) $display("FAIL pp_full: got %0d want 4", lvl0); else n_pass++;
    rdy_manual = 1'b1;
    @(negedge clk);
    b0.in_data  = w[4];
    b0.in_avail = 1'b1;
    tick();  // pop and push on the same edge
    n_checks++; if (op0 !== 1'b0) $display("FAIL pp_no_drop: got %b want 0", op0); else n_pass++;
    n_checks++; if (lvl0 !== 3'd4) $display("FAIL pp_level: got %0d want 4", lvl0); else n_pass++;
    n_checks++; if (b0.out_send !== 1'b1) $display("FAIL pp_send: got %b want 1", b0.out_send); else n_pass++;
    n_checks++; if (b0.out_data !== w[0]) $display("FAIL pp_head: got %h want %h", b0.out_data, w[0]); else n_pass++;
    b0.in_avail = 1'b0;
    auto_rdy = 1'b1; hold_k = 0; low_l = 2;
    drain(5);
    n_checks++; if (got0.size() != 5) $display("FAIL pp_count: got %0d want 5", got0.size()); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (got0[i] !== w[i]) $display("FAIL pp_order[%0d]: got %h want %h", i, got0[i], w[i]);
      else n_pass++;
    end
    n_checks++; if (oc0 !== 8'd0) $display("FAIL pp_ovf_cnt: got %0d want 0", oc0); else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    logic [31:0] nw;
    bit          seen;
    do_reset();
    for (int i = 0; i < 3; i++) push_word(32'hA000_0000 + 32'(i));
    tick();
    rdy_manual = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (b0.out_send) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL rms_strobe: got none want strobe"); else n_pass++;
    nw = $urandom;
    rst_n       = 1'b0;
    b0.in_data  = nw;
    b0.in_avail = 1'b1;
    #1;
    n_checks++; if (b0.out_send !== 1'b0) $display("FAIL rms_send: got %b want 0", b0.out_send); else n_pass++;
    n_checks++; if (b0.out_data !== 32'h0) $display("FAIL rms_data: got %h want 0", b0.out_data); else n_pass++;
    n_checks++; if (lvl0 !== 3'd0) $display("FAIL rms_level: got %0d want 0", lvl0); else n_pass++;
    clear_obs();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) tick();
    n_checks++; if (got0.size() != 1) $display("FAIL rms_sends: got %0d want 1", got0.size()); else n_pass++;
    n_checks++; if (got0[0] !== nw) $display("FAIL rms_new_word: got %h want %h", got0[0], nw); else n_pass++;
    n_checks++; if (lvl0 !== 3'd0) $display("FAIL rms_level_end: got %0d want 0", lvl0); else n_pass++;
    b0.in_avail = 1'b0;
    rdy_manual  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    int          total_drops;
    int          n;
    int          drops;
    bit          ready_low;
    logic [31:0] d;
    do_reset();
    total_drops = 0;
    for (int b = 0; b < 12; b++) begin
      clear_obs();
      exp_q.delete();
      ready_low = 1'($urandom_range(0, 1));
      if (ready_low) begin
        n = $urandom_range(1, 7);
        auto_rdy = 1'b0; rdy_manual = 1'b0;
      end else begin
        n = $urandom_range(1, 4);
        hold_k = $urandom_range(0, 2); low_l = $urandom_range(1, 3);
        auto_rdy = 1'b1;
      end
      repeat (2) tick();
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        push_word(d);
        if (!ready_low || i < 4) exp_q.push_back(d);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      tick();
      drops = ready_low && n > 4 ? n - 4 : 0;
      total_drops += drops;
      if (ready_low) begin
        n_checks++;
        if (lvl0 !== 3'(exp_q.size())) $display("FAIL rnd_level[%0d]: got %0d want %0d", b, lvl0, exp_q.size());
        else n_pass++;
      end
      n_checks++; if (pulses != drops) $display("FAIL rnd_pulses[%0d]: got %0d want %0d", b, pulses, drops); else n_pass++;
      auto_rdy = 1'b1;
      drain(exp_q.size());
      n_checks++;
      if (got0.size() != exp_q.size()) $display("FAIL rnd_count[%0d]: got %0d want %0d", b, got0.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got0[i] !== xf(0, exp_q[i]) || got1[i] !== xf(1, exp_q[i]) ||
            got2[i] !== xf(2, exp_q[i]) || got3[i] !== xf(3, exp_q[i]))
          $display("FAIL rnd_word[%0d.%0d]: got %h/%h/%h/%h want %h/%h/%h/%h", b, i,
                   got0[i], got1[i], got2[i], got3[i],
                   xf(0, exp_q[i]), xf(1, exp_q[i]), xf(2, exp_q[i]), xf(3, exp_q[i]));
        else n_pass++;
      end
      n_checks++; if (lvl0 !== 3'd0) $display("FAIL rnd_level_end[%0d]: got %0d want 0", b, lvl0); else n_pass++;
      n_checks++;
      if (oc0 !== 8'(total_drops > 255 ? 255 : total_drops))
        $display("FAIL rnd_ovf_cnt[%0d]: got %0d want %0d", b, oc0, total_drops);
      else n_pass++;
    end
  endtask

  task automatic test_ovf_saturate();
    do_reset();
    for (int i = 0; i < 264; i++) push_word(32'(i));
    tick();
    n_checks++; if (oc0 !== 8'hFF) $display("FAIL sat_cnt: got %0d want 255", oc0); else n_pass++;
    n_checks++; if (pulses != 260) $display("FAIL sat_pulses: got %0d want 260", pulses); else n_pass++;
    n_checks++; if (lvl0 !== 3'd4) $display("FAIL sat_level: got %0d want 4", lvl0); else n_pass++;
  endtask

  initial begin
    b0.in_data  = '0;
    b0.in_avail = 1'b0;
    test_reset();
    test_echo();
    test_transform();
    test_overflow();
    test_held_avail();
    test_full_push_pop();
    test_reset_mid_send();
    test_random();
    test_ovf_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
